// File: rtl/counter_sequencer.sv
// Command-side controller for the lab's 0..12 saturating up/down counter.
// Loads a start value, sweeps up and down between the rails, and checks the returned count.
module counter_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] start_val,
  input  logic [3:0] sweeps,
  input  logic [3:0] cnt_in,
  output logic       en,
  output logic       dir,
  output logic       load,
  output logic [5:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] sweep_cnt
);

  localparam logic [3:0] CEIL = 4'd12;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] v, sw_lat, expv, exp_nxt;
  logic [4:0] sc_inc;
  logic       stepping, cmd, hit, last;

  assign stepping = (state == S_UP) || (state == S_DOWN);
  assign cmd      = (state == S_LOAD) || (stepping && !pause);
  assign sc_inc   = {1'b0, sweep_cnt} + 5'd1;
  assign last     = (sc_inc == {1'b0, sw_lat});

  always_comb begin
    exp_nxt = expv;
    case (state)
      S_LOAD:  exp_nxt = v;
      S_UP:    exp_nxt = expv + 4'd1;
      S_DOWN:  exp_nxt = expv - 4'd1;
      default: exp_nxt = expv;
    endcase
  end

  // A reversal is the step that lands on a rail in the current sweep direction.
  assign hit = cmd && (((state == S_UP) && (exp_nxt == CEIL)) ||
                       ((state == S_DOWN) && (exp_nxt == 4'd0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (sw_lat == 4'd0)  state_nxt = S_DONE;
        else if (v == CEIL)  state_nxt = S_DOWN;
        else                 state_nxt = S_UP;
      end
      S_UP:   if (hit) state_nxt = last ? S_DONE : S_DOWN;
      S_DOWN: if (hit) state_nxt = last ? S_DONE : S_UP;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    en   = 1'b0;
    dir  = 1'b1;
    load = 1'b0;
    data = 6'd0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_LOAD: begin
        en   = 1'b1;
        load = 1'b1;
        data = {2'b00, v};
        busy = 1'b1;
      end
      S_UP: begin
        en   = !pause;
        busy = 1'b1;
      end
      S_DOWN: begin
        en   = !pause;
        dir  = 1'b0;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Run datapath: latched run parameters, expected count, reversal count, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= 4'd0;
      sw_lat    <= 4'd0;
      expv      <= 4'd0;
      sweep_cnt <= 4'd0;
      err       <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        v         <= (start_val > CEIL) ? CEIL : start_val;
        sw_lat    <= sweeps;
        sweep_cnt <= 4'd0;
        err       <= 1'b0;
      end
      if (cmd) begin
        expv <= exp_nxt;
        if (cnt_in != exp_nxt) err <= 1'b1;
      end
      if (hit && (sweep_cnt != 4'hF)) sweep_cnt <= sweep_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: lab counter model on cnt_in, a per-run expected command
// list built from the sweep rules, and a negedge compare against it.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0;
  logic [3:0] start_val = 4'd0, sweeps = 4'd0, cnt_in;
  logic       en, dir, load, busy, done, err;
  logic [5:0] data;
  logic [3:0] sweep_cnt;

  int tests = 0, fails = 0;

  counter_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .start_val(start_val),
    .sweeps(sweeps), .cnt_in(cnt_in), .en(en), .dir(dir), .load(load), .data(data),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // Lab counter: falling-edge, saturating 0..12, with a forced-read override.
  logic [3:0] cnt = 4'd0;
  logic       force_en = 1'b0;
  assign cnt_in = force_en ? 4'd7 : cnt;
  always @(negedge clk) begin
    if (load)    cnt <= data[3:0];
    else if (en) cnt <= dir ? ((cnt < 4'd12) ? cnt + 4'd1 : cnt) : ((cnt > 4'd0) ? cnt - 4'd1 : cnt);
  end

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Model: one record per cycle of a run, built from (start_val, sweeps).
  typedef enum {K_LOAD, K_UP, K_DOWN, K_DONE} kind_t;
  typedef struct { kind_t kind; logic [3:0] val; logic [3:0] sc; } rec_t;
  rec_t       mq[$];
  logic       m_err = 1'b0;
  logic [3:0] m_sc = 4'd0;

  task automatic build(input logic [3:0] sv, input logic [3:0] sw);
    int e, sc;
    bit up;
    rec_t r;
    e = (sv > 12) ? 12 : int'(sv);
    sc = 0;
    r.kind = K_LOAD; r.val = 4'(e); r.sc = 4'd0;
    mq.push_back(r);
    if (sw != 0) begin
      up = (e != 12);
      for (int g = 0; g < 400; g++) begin
        r.kind = up ? K_UP : K_DOWN;
        r.sc   = 4'(sc);
        e      = up ? e + 1 : e - 1;
        r.val  = 4'(e);
        mq.push_back(r);
        if ((up && e == 12) || (!up && e == 0)) begin
          sc++;
          up = !up;
          if (sc == int'(sw)) break;
        end
      end
    end
    r.kind = K_DONE; r.val = 4'd0; r.sc = 4'(sc);
    mq.push_back(r);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
      m_sc  = 4'd0;
    end else if (mq.size() == 0) begin
      if (start) begin
        build(start_val, sweeps);
        m_err = 1'b0;
        m_sc  = 4'd0;
      end
    end else if (mq[0].kind == K_DONE) begin
      m_sc = mq[0].sc;
      void'(mq.pop_front());
    end else if (!(pause && mq[0].kind != K_LOAD)) begin
      if (cnt_in != mq[0].val) m_err = 1'b1;
      void'(mq.pop_front());
    end
  end

  int         run_busy = 0, done_cnt = 0;
  logic [5:0] last_data = 6'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) run_busy++;
      if (done) done_cnt++;
      if (load) last_data = data;
      chk("err", err, m_err);
      if (mq.size() == 0) begin
        chk("idle_en", en, 0);     chk("idle_load", load, 0); chk("idle_dir", dir, 1);
        chk("idle_data", data, 0); chk("idle_busy", busy, 0); chk("idle_done", done, 0);
        chk("idle_sweep_cnt", sweep_cnt, m_sc);
      end else begin
        chk("sweep_cnt", sweep_cnt, mq[0].sc);
        case (mq[0].kind)
          K_LOAD: begin
            chk("load_en", en, 1); chk("load_load", load, 1);
            chk("load_data", data, mq[0].val); chk("load_busy", busy, 1); chk("load_done", done, 0);
          end
          K_UP, K_DOWN: begin
            chk("step_en", en, !pause); chk("step_load", load, 0);
            chk("step_dir", dir, mq[0].kind == K_UP); chk("step_busy", busy, 1); chk("step_done", done, 0);
          end
          default: begin
            chk("done_done", done, 1); chk("done_busy", busy, 0);
            chk("done_en", en, 0);     chk("done_load", load, 0);
          end
        endcase
      end
    end
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE. c=0 is the LOAD cycle.
  task automatic run(input logic [3:0] sv, input logic [3:0] sw,
                     input int p_at, input int p_len, input int f_at, input int s_at);
    int d0, c;
    d0 = done_cnt;
    run_busy = 0;
    start_val = sv; sweeps = sw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (done_cnt == d0 && c < 300) begin
      pause    = (c >= p_at) && (c < p_at + p_len);
      force_en = (c == f_at);
      start    = (c == s_at);
      @(posedge clk); #1;
      c++;
    end
    pause = 1'b0; force_en = 1'b0; start = 1'b0;
    tests++;
    if (c >= 300) begin
      fails++;
      $display("FAIL run_timeout: no done within %0d cycles", c);
    end
  endtask

  localparam int NO = 1000;

  initial begin
    int d0;
    #2;
    chk("rst_busy", busy, 0); chk("rst_en", en, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0);   chk("rst_sweep_cnt", sweep_cnt, 0); chk("rst_dir", dir, 1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Basic run: 1 load + 9 up + 12 down
    run(4'd3, 4'd2, NO, 0, NO, NO);
    chk("basic_busy_cycles", run_busy, 22); chk("basic_done_cnt", done_cnt, 1);
    chk("basic_load_data", last_data, 3);   chk("basic_err", err, 0);
    chk("basic_cnt_end", cnt, 0);           chk("basic_sweep_cnt", sweep_cnt, 2);

    // Clamp: 15 loads as 12, straight to DOWN
    run(4'd15, 4'd1, NO, 0, NO, NO);
    chk("clamp_load_data", last_data, 12); chk("clamp_busy_cycles", run_busy, 13);
    chk("clamp_err", err, 0);              chk("clamp_cnt_end", cnt, 0);

    // Pause for 5 cycles mid-UP
    run(4'd3, 4'd1, 4, 5, NO, NO);
    chk("pause_busy_cycles", run_busy, 15); chk("pause_err", err, 0); chk("pause_cnt_end", cnt, 12);

    // Mismatch: cnt_in reads 7 in the cycle whose expected count is 5
    run(4'd3, 4'd1, NO, 0, 2, NO);
    chk("mismatch_err_sticky", err, 1);

    // sweeps=0: LOAD then DONE; start clears err
    run(4'd5, 4'd0, NO, 0, NO, NO);
    chk("zero_busy_cycles", run_busy, 1); chk("zero_err_cleared", err, 0);
    chk("zero_sweep_cnt", sweep_cnt, 0);

    // Start pulsed mid-run is ignored
    d0 = done_cnt;
    run(4'd3, 4'd2, NO, 0, NO, 5);
    chk("poke_busy_cycles", run_busy, 22); chk("poke_done_cnt", done_cnt - d0, 1);

    // Async reset in the DOWN leg after one reversal
    start_val = 4'd0; sweeps = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    chk("pre_rst_sweep_cnt", sweep_cnt, 1); chk("pre_rst_dir", dir, 0);
    d0 = done_cnt;
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("arst_busy", busy, 0); chk("arst_en", en, 0);
    chk("arst_sweep_cnt", sweep_cnt, 0); chk("arst_done", done, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("arst_no_done", done_cnt, d0); chk("arst_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
